vscale_wb_stage: RTL and testbench

- Writeback-end counterpart of the DX operand-select path. Operand muxes choose what enters the ALU; this block takes what leaves execute and writes it back.
- Registers the DX→WB pipeline state and selects the writeback source (ALU, PC+4, CSR, load).
- Aligns and sign/zero-extends load data, and holds load data that arrives during a stall.
- Drives the regfile write port and the WB bypass value back to the DX operand muxes.

---
 rtl/vscale_wb_stage.sv | 110 +++++++++++
 tb/tb_vscale_wb_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_wb_stage.sv
// Writeback stage: registers DX->WB state, selects the writeback source,
// aligns/extends load data and holds a load result that arrives during a stall.
module vscale_wb_stage #(
    parameter int XPR_LEN        = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall_WB,
    input  logic                      kill_DX,
    input  logic                      wr_reg_DX,
    input  logic [REG_ADDR_WIDTH-1:0] reg_to_wr_DX,
    input  logic [1:0]                wb_src_sel_DX,
    input  logic [XPR_LEN-1:0]        alu_out_DX,
    input  logic [XPR_LEN-1:0]        PC_DX,
    input  logic [2:0]                dmem_type_DX,
    input  logic [XPR_LEN-1:0]        csr_rdata,
    input  logic [XPR_LEN-1:0]        dmem_rdata,
    input  logic                      dmem_wait,
    output logic                      wr_reg_WB,
    output logic [REG_ADDR_WIDTH-1:0] reg_to_wr_WB,
    output logic [XPR_LEN-1:0]        wb_data_WB,
    output logic [XPR_LEN-1:0]        bypass_data_WB,
    output logic [XPR_LEN-1:0]        PC_WB,
    output logic                      load_stall_WB
);

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_PC4 = 2'd1,
        WB_SRC_CSR = 2'd2,
        WB_SRC_MEM = 2'd3
    } wb_src_e;

    localparam logic [2:0] MEM_LB  = 3'd0;
    localparam logic [2:0] MEM_LH  = 3'd1;
    localparam logic [2:0] MEM_LBU = 3'd4;
    localparam logic [2:0] MEM_LHU = 3'd5;

    logic               wr_valid_q;
    wb_src_e            src_q;
    logic [1:0]         byte_off_q;
    logic [2:0]         dmem_type_q;
    logic [XPR_LEN-1:0] result_q;
    logic [XPR_LEN-1:0] hold_q;
    logic               load_done_q;

    logic [7:0]         load_byte;
    logic [15:0]        load_half;
    logic [XPR_LEN-1:0] load_ext;

    // Only the low address bits survive into WB; the full ALU value is already in result_q.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement order.
        if (reset) begin
            wr_valid_q   <= 1'b0;
            reg_to_wr_WB <= '0;
            src_q        <= WB_SRC_ALU;
            byte_off_q   <= '0;
            dmem_type_q  <= '0;
            result_q     <= '0;
            PC_WB        <= '0;
            hold_q       <= '0;
            load_done_q  <= 1'b0;
        end else if (!stall_WB) begin
            wr_valid_q   <= wr_reg_DX && !kill_DX && (reg_to_wr_DX != '0);
            reg_to_wr_WB <= reg_to_wr_DX;
            src_q        <= wb_src_e'(wb_src_sel_DX);
            byte_off_q   <= alu_out_DX[1:0];
            dmem_type_q  <= dmem_type_DX;
            PC_WB        <= PC_DX;
            load_done_q  <= 1'b0;
            unique case (wb_src_e'(wb_src_sel_DX))
                WB_SRC_PC4: result_q <= PC_DX + XPR_LEN'(4);
                WB_SRC_CSR: result_q <= csr_rdata;
                default:    result_q <= alu_out_DX;
            endcase
        end else if (src_q == WB_SRC_MEM && !load_done_q && !dmem_wait) begin
            hold_q      <= load_ext;
            load_done_q <= 1'b1;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        load_byte = dmem_rdata[{byte_off_q, 3'b000} +: 8];
        load_half = dmem_rdata[{byte_off_q[1], 4'b0000} +: 16];
        load_ext  = dmem_rdata;
        case (dmem_type_q)
            MEM_LB:  load_ext = {{(XPR_LEN-8){load_byte[7]}}, load_byte};
            MEM_LH:  load_ext = {{(XPR_LEN-16){load_half[15]}}, load_half};
            MEM_LBU: load_ext = {{(XPR_LEN-8){1'b0}}, load_byte};
            MEM_LHU: load_ext = {{(XPR_LEN-16){1'b0}}, load_half};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        wb_data_WB = result_q;
        if (src_q == WB_SRC_MEM)
            wb_data_WB = load_done_q ? hold_q : load_ext;
    end

    assign bypass_data_WB = wb_data_WB;
    assign load_stall_WB  = (src_q == WB_SRC_MEM) && wr_valid_q && !load_done_q && dmem_wait;
    assign wr_reg_WB      = wr_valid_q && !load_stall_WB;

endmodule

// File: tb/tb_vscale_wb_stage.sv
// Scoreboard bench for vscale_wb_stage: stimulus queues expected WB outputs per
// cycle, a negedge monitor pops and compares them.
module tb_vscale_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_WB;
    logic        kill_DX;
    logic        wr_reg_DX;
    logic [4:0]  reg_to_wr_DX;
    logic [1:0]  wb_src_sel_DX;
    logic [31:0] alu_out_DX;
    logic [31:0] PC_DX;
    logic [2:0]  dmem_type_DX;
    logic [31:0] csr_rdata;
    logic [31:0] dmem_rdata;
    logic        dmem_wait;
    logic        wr_reg_WB;
    logic [4:0]  reg_to_wr_WB;
    logic [31:0] wb_data_WB;
    logic [31:0] bypass_data_WB;
    logic [31:0] PC_WB;
    logic        load_stall_WB;

    vscale_wb_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall_WB       (stall_WB),
        .kill_DX        (kill_DX),
        .wr_reg_DX      (wr_reg_DX),
        .reg_to_wr_DX   (reg_to_wr_DX),
        .wb_src_sel_DX  (wb_src_sel_DX),
        .alu_out_DX     (alu_out_DX),
        .PC_DX          (PC_DX),
        .dmem_type_DX   (dmem_type_DX),
        .csr_rdata      (csr_rdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_wait      (dmem_wait),
        .wr_reg_WB      (wr_reg_WB),
        .reg_to_wr_WB   (reg_to_wr_WB),
        .wb_data_WB     (wb_data_WB),
        .bypass_data_WB (bypass_data_WB),
        .PC_WB          (PC_WB),
        .load_stall_WB  (load_stall_WB)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        logic        wr;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] pc;
        logic        ls;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: compares whatever the stimulus queued for this cycle.
    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc != cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: expectation for cycle %0d not checked, now %0d", e.name, e.cyc, cyc);
            end else begin
                check({e.name, ".wr_reg"},  {31'b0, wr_reg_WB},     {31'b0, e.wr});
                check({e.name, ".rd"},      {27'b0, reg_to_wr_WB},  {27'b0, e.rd});
                check({e.name, ".data"},    wb_data_WB,             e.data);
                check({e.name, ".bypass"},  bypass_data_WB,         e.data);
                check({e.name, ".pc"},      PC_WB,                  e.pc);
                check({e.name, ".ld_stall"},{31'b0, load_stall_WB}, {31'b0, e.ls});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_dx(input logic wr, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] pc,
                            input logic [2:0] typ, input logic [31:0] csr);
        wr_reg_DX     = wr;
        reg_to_wr_DX  = rd;
        wb_src_sel_DX = sel;
        alu_out_DX    = alu;
        PC_DX         = pc;
        dmem_type_DX  = typ;
        csr_rdata     = csr;
    endtask

    task automatic exp_wb(input string name, input logic wr, input logic [4:0] rd,
                          input logic [31:0] data, input logic [31:0] pc, input logic ls);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.wr   = wr;
        e.rd   = rd;
        e.data = data;
        e.pc   = pc;
        e.ls   = ls;
        q.push_back(e);
    endtask

    typedef struct {
        logic [1:0]  off;
        logic [2:0]  typ;
        logic [31:0] res;
    } load_vec_t;

    load_vec_t loads[6] = '{
        '{2'd3, 3'd0, 32'hFFFFFF80},   // LB  off3
        '{2'd1, 3'd4, 32'h0000007F},   // LBU off1
        '{2'd2, 3'd1, 32'hFFFF80FF},   // LH  off2
        '{2'd0, 3'd5, 32'h00007F01},   // LHU off0
        '{2'd0, 3'd2, 32'h80FF7F01},   // LW
        '{2'd1, 3'd1, 32'h00007F01}    // LH  off1 acts as off0
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; stall_WB = 1'b0; kill_DX = 1'b0;
        dmem_rdata = '0; dmem_wait = 1'b0;
        drive_dx(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 3'd0, 32'h0);
        tick();
        // Reset held with a live instruction on DX: outputs stay zero.
        drive_dx(1'b1, 5'd5, 2'd0, 32'h1234, 32'h40, 3'd0, 32'h0);
        tick();
        exp_wb("reset", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;

        tick();
        exp_wb("alu", 1'b1, 5'd5, 32'h1234, 32'h40, 1'b0);
        drive_dx(1'b1, 5'd1, 2'd1, 32'h0, 32'hFFFF_FFFC, 3'd0, 32'h0);
        tick();
        exp_wb("jal_wrap", 1'b1, 5'd1, 32'h0, 32'hFFFF_FFFC, 1'b0);
        drive_dx(1'b1, 5'd2, 2'd1, 32'h0, 32'h100, 3'd0, 32'h0);
        tick();
        exp_wb("jal", 1'b1, 5'd2, 32'h104, 32'h100, 1'b0);
        drive_dx(1'b1, 5'd3, 2'd2, 32'h0, 32'h108, 3'd0, 32'hDEAD_BEEF);
        tick();
        exp_wb("csr", 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h108, 1'b0);

        dmem_rdata = 32'h80FF_7F01;
        for (int i = 0; i < 6; i++) begin
            drive_dx(1'b1, 5'(6 + i), 2'd3, {30'h80, loads[i].off}, 32'h80, loads[i].typ, 32'h0);
            tick();
            exp_wb($sformatf("load%0d", i), 1'b1, 5'(6 + i), loads[i].res, 32'h80, 1'b0);
        end

        kill_DX = 1'b1;
        drive_dx(1'b1, 5'd12, 2'd0, 32'h77, 32'h90, 3'd0, 32'h0);
        tick();
        exp_wb("kill", 1'b0, 5'd12, 32'h77, 32'h90, 1'b0);
        kill_DX = 1'b0;
        drive_dx(1'b1, 5'd0, 2'd0, 32'h99, 32'h94, 3'd0, 32'h0);
        tick();
        exp_wb("x0", 1'b0, 5'd0, 32'h99, 32'h94, 1'b0);

        // LW waits three cycles, data then arrives while WB is still stalled.
        drive_dx(1'b1, 5'd13, 2'd3, 32'h200, 32'hA0, 3'd2, 32'h0);
        tick();
        stall_WB = 1'b1; dmem_wait = 1'b1; dmem_rdata = 32'h1234_5678;
        drive_dx(1'b1, 5'd20, 2'd0, 32'h3, 32'hA4, 3'd0, 32'h0);
        exp_wb("wait0", 1'b0, 5'd13, 32'h1234_5678, 32'hA0, 1'b1);
        for (int i = 1; i < 3; i++) begin
            tick();
            exp_wb($sformatf("wait%0d", i), 1'b0, 5'd13, 32'h1234_5678, 32'hA0, 1'b1);
        end
        tick();
        dmem_wait = 1'b0; dmem_rdata = 32'hAA;
        exp_wb("arrive", 1'b1, 5'd13, 32'hAA, 32'hA0, 1'b0);
        tick();
        dmem_rdata = 32'h55; dmem_wait = 1'b1;
        exp_wb("hold_wait", 1'b1, 5'd13, 32'hAA, 32'hA0, 1'b0);
        tick();
        dmem_wait = 1'b0;
        exp_wb("hold", 1'b1, 5'd13, 32'hAA, 32'hA0, 1'b0);
        stall_WB = 1'b0;
        drive_dx(1'b1, 5'd15, 2'd0, 32'hCAFE, 32'h300, 3'd0, 32'h0);
        tick();
        exp_wb("after_hold", 1'b1, 5'd15, 32'hCAFE, 32'h300, 1'b0);

        // Stall holds everything while DX toggles, kill included.
        stall_WB = 1'b1;
        for (int i = 0; i < 4; i++) begin
            kill_DX = i[0];
            drive_dx(i[1], 5'(17 + i), 2'(i), 32'h1111 * (i + 1), 32'h400 + 32'(4 * i), 3'(i), 32'h5A5A);
            tick();
            exp_wb($sformatf("stall%0d", i), 1'b1, 5'd15, 32'hCAFE, 32'h300, 1'b0);
        end
        stall_WB = 1'b0; kill_DX = 1'b0;

        // Fresh load must start without stale load_done, then reset kills it.
        drive_dx(1'b1, 5'd16, 2'd3, 32'h0, 32'h500, 3'd2, 32'h0);
        tick();
        stall_WB = 1'b1; dmem_wait = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        exp_wb("load_wait", 1'b0, 5'd16, 32'h0BAD_F00D, 32'h500, 1'b1);
        reset = 1'b1;
        tick();
        exp_wb("reset_mid_load", 1'b0, 5'd0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0; stall_WB = 1'b0; dmem_wait = 1'b0;

        tick();
        tick();
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
